// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port register file with NUM_RD combinational read ports,
//             write-through bypass, two prioritised write ports, a per-
//             register busy scoreboard and a hardware clear sweep that runs
//             after reset or on flush.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  output logic                     init_done,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr
);

  localparam int                DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_FIRST  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST   = '1;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                   state_q;
  logic [ADDR_W-1:0]        ptr_q;
  logic                     init_done_q;
  logic [DEPTH-1:0]         busy_q;
  logic [DEPTH-1:0]         busy_d;
  logic [DATA_W-1:0]        regs_q [DEPTH];

  logic                     w_run;
  logic                     w_wr0;
  logic                     w_wr1;

  assign w_run     = (state_q == S_RUN);
  // Register 0 is hardwired to zero, so writes to it never commit.
  assign w_wr0     = w_run && we0 && (waddr0 != '0);
  assign w_wr1     = w_run && we1 && (waddr1 != '0);
  assign init_done = init_done_q;

  // Scoreboard next state: entering/being in INIT clears everything;
  // otherwise committed writes clear and busy_set sets, with set winning.
  always_comb begin
    busy_d = busy_q;
    if (!w_run || flush) begin
      busy_d = '0;
    end else begin
      if (w_wr0) busy_d[waddr0] = 1'b0;
      if (w_wr1) busy_d[waddr1] = 1'b0;
      if (busy_set && (busy_addr != '0)) busy_d[busy_addr] = 1'b1;
    end
  end

  // Sweep/run control FSM with registered init_done and the busy scoreboard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      ptr_q       <= PTR_FIRST;
      init_done_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      busy_q <= busy_d;
      case (state_q)
        S_INIT: begin
          if (flush) begin
            ptr_q <= PTR_FIRST;
          end else if (ptr_q == PTR_LAST) begin
            state_q     <= S_RUN;
            ptr_q       <= PTR_FIRST;
            init_done_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + PTR_FIRST;
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q     <= S_INIT;
            ptr_q       <= PTR_FIRST;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_INIT;
          ptr_q       <= PTR_FIRST;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage: sweep clears one entry per cycle in INIT; in RUN port 1 is
  // issued last so it wins an address collision. Contents are not reset.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      regs_q[ptr_q] <= '0;
    end else begin
      if (w_wr0) regs_q[waddr0] <= wdata0;
      if (w_wr1) regs_q[waddr1] <= wdata1;
    end
  end

  // Per-port read path: zero in INIT / disabled / r0, then bypass, then storage.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_val;
    logic              rb_val;

    assign ra = raddr[k*ADDR_W +: ADDR_W];

    // Select the read source for this port in priority order.
    always_comb begin
      rd_val = '0;
      rb_val = 1'b0;
      if (!w_run || !re[k] || (ra == '0)) begin
        rd_val = '0;
        rb_val = 1'b0;
      end else if (we1 && (waddr1 == ra)) begin
        rd_val = wdata1;
      end else if (we0 && (waddr0 == ra)) begin
        rd_val = wdata0;
      end else begin
        rd_val = regs_q[ra];
        rb_val = busy_q[ra];
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = rd_val;
    assign rbusy[k]                  = rb_val;
  end

endmodule
`default_nettype wire
